// File: rtl/seg_scan_mux.sv
// Time-multiplexed scanner for a common-anode multi-digit 7-segment display, with
// frame-boundary double buffering. Optional leading-zero blanking: LEADING_ZERO_BLANK_EN.
module seg_scan_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic [4*NUM_DIGITS-1:0]       digits_in,
  output logic [3:0]                    nibble,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_tick,
  output logic                          pending
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int DW    = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {S_BLANK, S_DRIVE} slot_e;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DW-1:0]    disp_q, disp_d;
  logic [DW-1:0]    hold_q, hold_d;
  logic             pending_q, pending_d;
  logic             frame_tick_q, frame_tick_d;

  logic             slot_end;
  logic             wrap;
  slot_e            slot_state;
  logic             lz_blank;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_q       <= '0;
      hold_q       <= '0;
      pending_q    <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      hold_q       <= hold_d;
      pending_q    <= pending_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  // Next-state: slot/frame sequencing and the double-buffer transfer at the wrap
  always_comb begin
    slot_end     = (cnt_q == CNT_LAST);
    wrap         = slot_end && (idx_q == IDX_LAST);
    cnt_d        = slot_end ? '0 : cnt_q + CNT_W'(1);
    idx_d        = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    hold_d       = load ? digits_in : hold_q;
    pending_d    = pending_q;
    disp_d       = disp_q;
    frame_tick_d = wrap;
    if (wrap) begin
      // A load landing on the wrap itself bypasses hold so it is not lost a frame.
      if (load)           disp_d = digits_in;
      else if (pending_q) disp_d = hold_q;
      pending_d = 1'b0;
    end else if (load) begin
      pending_d = 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] zero_from;

  // zero_from[k]: digit k and every more-significant digit are zero
  always_comb begin
    zero_from = '0;
    zero_from[NUM_DIGITS-1] = (disp_q[4*(NUM_DIGITS-1) +: 4] == 4'h0);
    for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
      zero_from[k] = (disp_q[4*k +: 4] == 4'h0) && zero_from[k+1];
    end
    lz_blank = (idx_q != '0) && zero_from[idx_q];
  end
`else
  assign lz_blank = 1'b0;
`endif

  // Outputs: decoded from registered state only
  always_comb begin
    slot_state = (cnt_q < BLANK_END) ? S_BLANK : S_DRIVE;
    an         = '1;
    if (slot_state == S_DRIVE && !lz_blank) an[idx_q] = 1'b0;
    nibble     = disp_q[{idx_q, 2'b00} +: 4];
    digit_idx  = idx_q;
    frame_tick = frame_tick_q;
    pending    = pending_q;
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux (4 digits, 8-cycle slots, 2 blank cycles) with a
// scoreboard queue of expected per-cycle outputs.
module tb_seg_scan_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  nibble;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        frame_tick;
  logic        pending;

  seg_scan_mux #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in),
    .nibble(nibble), .an(an), .digit_idx(digit_idx),
    .frame_tick(frame_tick), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [3:0] nibble;
    logic [1:0] idx;
    logic       pend;
    logic       ft;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   exp_pend = 0;
  bit   exp_ft   = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [3:0] exp_an(input int pos, input logic [15:0] disp);
    int slot = pos / 8;
    if (pos % 8 < 2) return 4'hF;
`ifdef LEADING_ZERO_BLANK_EN
    if (slot > 0 && (disp >> (4 * slot)) == 16'h0) return 4'hF;
`endif
    return ~(4'b0001 << slot);
  endfunction

  // Check the current cycle against the expectation for a frame showing disp,
  // optionally drive a load during it, then advance one clock.
  task automatic step_check(input logic [15:0] disp, input bit ld, input logic [15:0] val);
    int   pos = cyc % 32;
    exp_t e;
    exp_t got;
    e.an     = exp_an(pos, disp);
    e.nibble = disp[4*(pos/8) +: 4];
    e.idx    = 2'(pos / 8);
    e.pend   = exp_pend;
    e.ft     = exp_ft;
    sb.push_back(e);
    got = sb.pop_front();
    chk("an", 16'(an), 16'(got.an));
    chk("nibble", 16'(nibble), 16'(got.nibble));
    chk("digit_idx", 16'(digit_idx), 16'(got.idx));
    chk("pending", 16'(pending), 16'(got.pend));
    chk("frame_tick", 16'(frame_tick), 16'(got.ft));
    if (ld) begin
      load = 1'b1;
      digits_in = val;
    end
    tick();
    load = 1'b0;
    exp_ft = (pos == 31);
    if (ld) exp_pend = (pos != 31);
    else if (pos == 31) exp_pend = 1'b0;
  endtask

  task automatic run_frame(input logic [15:0] disp,
                           input int p1, input logic [15:0] v1,
                           input int p2, input logic [15:0] v2);
    for (int i = 0; i < 32; i++) begin
      if (i == p1)      step_check(disp, 1'b1, v1);
      else if (i == p2) step_check(disp, 1'b1, v2);
      else              step_check(disp, 1'b0, 16'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Test 1: reset held for three edges, outputs idle
    rst = 1'b1;
    tick();
    chk("rst_an", 16'(an), 16'hF);
    chk("rst_nibble", 16'(nibble), 16'h0);
    chk("rst_idx", 16'(digit_idx), 16'h0);
    chk("rst_pending", 16'(pending), 16'h0);
    chk("rst_frame_tick", 16'(frame_tick), 16'h0);
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;

    // Test 1+2: idle frame, then a load of 1234 during idx=1
    run_frame(16'h0000, 11, 16'h1234, -1, 16'h0);
    // Test 2 continued: 1234 shown as 4,3,2,1; test 3 loads AAAA then 5678
    run_frame(16'h1234, 5, 16'hAAAA, 20, 16'h5678);
    // Test 3 result; test 4 loads 9999 on the wrap cycle
    run_frame(16'h5678, 31, 16'h9999, -1, 16'h0);
    run_frame(16'h9999, -1, 16'h0, -1, 16'h0);

    // Test 5: reset mid-DRIVE of idx=2 with a pending load
    for (int i = 0; i < 19; i++) begin
      if (i == 2) step_check(16'h9999, 1'b1, 16'h1111);
      else        step_check(16'h9999, 1'b0, 16'h0);
    end
    chk("pre_rst_an", 16'(an), 16'hB);
    chk("pre_rst_pending", 16'(pending), 16'h1);
    rst = 1'b1;
    tick();
    chk("mid_rst_an", 16'(an), 16'hF);
    chk("mid_rst_idx", 16'(digit_idx), 16'h0);
    chk("mid_rst_pending", 16'(pending), 16'h0);
    chk("mid_rst_nibble", 16'(nibble), 16'h0);
    rst = 1'b0;
    cyc = 0;
    exp_pend = 1'b0;
    exp_ft = 1'b0;
    // Discarded load must not appear after the next wrap
    run_frame(16'h0000, -1, 16'h0, -1, 16'h0);
    run_frame(16'h0000, 31, 16'h0040, -1, 16'h0);

`ifdef LEADING_ZERO_BLANK_EN
    // Test 6: leading-zero blanking of 0040, then 0000
    run_frame(16'h0040, 31, 16'h0000, -1, 16'h0);
    run_frame(16'h0000, -1, 16'h0, -1, 16'h0);
`else
    run_frame(16'h0040, -1, 16'h0, -1, 16'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
